formula_chain_pipe: RTL

- Parametrised, fully pipelined evaluator of the nested square-root chain: res = isqrt(x[0] + isqrt(x[1] + ... + isqrt(x[N-1]))).
- Generalises the fixed three-argument form to N arguments of configurable width, with a selectable wrap/saturate rule on the adder stages.
- Adds an in-flight counter and a busy flag so downstream control can drain the pipe.
- Sits in the arithmetic/pipelining group and reuses the existing pipelined isqrt and shift_register_with_valid blocks.

---
 rtl/formula_chain_pipe.sv | 303 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/formula_chain_pipe.sv
// formula_chain_pipe: pipelined nested square-root chain
//   res = isqrt(x[0] + isqrt(x[1] + ... + isqrt(x[N_ARGS-1])))
// Contains the isqrt and shift_register_with_valid building blocks it chains.

// -----------------------------------------------------------------------------
// isqrt: digit-by-digit integer square root, W/2 iterations spread over
// N_PIPE_STAGES register stages. Latency is exactly N_PIPE_STAGES cycles.
// Active-high asynchronous reset clears the valid pipeline only.
// -----------------------------------------------------------------------------
module isqrt #(
  parameter int W             = 32,
  parameter int N_PIPE_STAGES = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_vld,
  input  logic [W-1:0]   in_data,
  output logic           out_vld,
  output logic [W/2-1:0] out_root
);
  localparam int I  = W / 2;
  localparam int RW = I + 3;
  localparam int L  = N_PIPE_STAGES;

  logic          stage_vld  [L];
  logic [W-1:0]  stage_x    [L];
  logic [RW-1:0] stage_rem  [L];
  logic [I-1:0]  stage_root [L];

  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : g_stage
      // Iterations [LO, HI) are evaluated in this stage; stages may be empty.
      localparam int LO = gi * I / L;
      localparam int HI = (gi + 1) * I / L;

      logic          vld_in;
      logic [W-1:0]  x_in;
      logic [RW-1:0] rem_in;
      logic [I-1:0]  root_in;
      logic [W-1:0]  x_v;
      logic [RW-1:0] rem_v;
      logic [I-1:0]  root_v;
      logic [RW-1:0] trial;
      logic          vld_d, vld_q;
      logic [W-1:0]  x_d, x_q;
      logic [RW-1:0] rem_d, rem_q;
      logic [I-1:0]  root_d, root_q;

      if (gi == 0) begin : g_src
        assign vld_in  = in_vld;
        assign x_in    = in_data;
        assign rem_in  = '0;
        assign root_in = '0;
      end else begin : g_src
        assign vld_in  = stage_vld[gi-1];
        assign x_in    = stage_x[gi-1];
        assign rem_in  = stage_rem[gi-1];
        assign root_in = stage_root[gi-1];
      end

      // Run this stage's root iterations; data registers only load on valid.
      always_comb begin
        x_v    = x_in;
        rem_v  = rem_in;
        root_v = root_in;
        trial  = '0;
        for (int i = 0; i < I; i++) begin
          if (i >= LO && i < HI) begin
            rem_v = {rem_v[RW-3:0], x_v[W-1:W-2]};
            x_v   = {x_v[W-3:0], 2'b00};
            trial = {1'b0, root_v, 2'b01};
            if (rem_v >= trial) begin
              rem_v  = rem_v - trial;
              root_v = {root_v[I-2:0], 1'b1};
            end else begin
              root_v = {root_v[I-2:0], 1'b0};
            end
          end
        end
        vld_d  = vld_in;
        x_d    = x_q;
        rem_d  = rem_q;
        root_d = root_q;
        if (vld_in) begin
          x_d    = x_v;
          rem_d  = rem_v;
          root_d = root_v;
        end
      end

      // Valid bit: cleared immediately by reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= 1'b0;
        else     vld_q <= vld_d;
      end

      // Data registers: no reset, contents at invalid slots are don't-care.
      always_ff @(posedge clk) begin
        x_q    <= x_d;
        rem_q  <= rem_d;
        root_q <= root_d;
      end

      assign stage_vld[gi]  = vld_q;
      assign stage_x[gi]    = x_q;
      assign stage_rem[gi]  = rem_q;
      assign stage_root[gi] = root_q;
    end
  endgenerate

  assign out_vld  = stage_vld[L-1];
  assign out_root = stage_root[L-1];

  // The final remainder and residual radicand are not needed downstream.
  logic unused_tail;
  assign unused_tail = ^{stage_x[L-1], stage_rem[L-1]};
endmodule

// -----------------------------------------------------------------------------
// shift_register_with_valid: DEPTH-cycle delay of a valid/data pair.
// Each data tap loads only when its incoming valid is high.
// -----------------------------------------------------------------------------
module shift_register_with_valid #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);
  logic             tap_vld  [DEPTH];
  logic [WIDTH-1:0] tap_data [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_tap
      logic             vld_in;
      logic [WIDTH-1:0] data_in;
      logic             vld_d, vld_q;
      logic [WIDTH-1:0] data_d, data_q;

      if (gi == 0) begin : g_src
        assign vld_in  = in_vld;
        assign data_in = in_data;
      end else begin : g_src
        assign vld_in  = tap_vld[gi-1];
        assign data_in = tap_data[gi-1];
      end

      // Advance valid every cycle; hold data unless a valid word arrives.
      always_comb begin
        vld_d  = vld_in;
        data_d = data_q;
        if (vld_in) data_d = data_in;
      end

      // Valid bit with asynchronous clear.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= 1'b0;
        else     vld_q <= vld_d;
      end

      // Data tap, no reset needed.
      always_ff @(posedge clk) begin
        data_q <= data_d;
      end

      assign tap_vld[gi]  = vld_q;
      assign tap_data[gi] = data_q;
    end
  endgenerate

  assign out_vld  = tap_vld[DEPTH-1];
  assign out_data = tap_data[DEPTH-1];
endmodule

// -----------------------------------------------------------------------------
// formula_chain_pipe: top level. Stage 0 takes the innermost argument; each
// later stage adds its (delayed) argument to the previous root and feeds the
// next isqrt. Total latency N_ARGS*ISQRT_STAGES cycles.
// -----------------------------------------------------------------------------
module formula_chain_pipe #(
  parameter int N_ARGS       = 3,
  parameter int W            = 32,
  parameter int ISQRT_STAGES = 4,
  parameter int SATURATE     = 0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        arg_vld,
  input  logic [N_ARGS*W-1:0]                         args,
  output logic                                        res_vld,
  output logic [W/2-1:0]                              res,
  output logic [$clog2(N_ARGS*ISQRT_STAGES+1)-1:0]    in_flight,
  output logic                                        busy
);
  localparam int L   = ISQRT_STAGES;
  localparam int MAX = N_ARGS * L;
  localparam int CW  = $clog2(MAX + 1);

  generate
    if ((W % 2) != 0 || W < 4 || N_ARGS < 1 || N_ARGS > 8 || L < 1 ||
        (SATURATE != 0 && SATURATE != 1)) begin : g_bad_params
      $error("formula_chain_pipe: illegal parameter combination");
    end
  endgenerate

  // Sub-blocks use an active-high reset.
  logic rst_hi;
  assign rst_hi = ~rst;

  logic              st_vld  [N_ARGS];
  logic [W-1:0]      st_in   [N_ARGS];
  logic [N_ARGS-1:0] iq_vld;
  logic [W/2-1:0]    iq_root [N_ARGS];

  genvar gi;
  generate
    for (gi = 0; gi < N_ARGS; gi++) begin : g_chain
      if (gi == 0) begin : g_feed
        assign st_vld[gi] = arg_vld;
        assign st_in[gi]  = args[(N_ARGS-1)*W +: W];
      end else begin : g_feed
        logic         dl_vld;
        logic [W-1:0] dl_data;
        logic [W:0]   sum_wide;
        logic [W-1:0] sum;

        // Align x[N_ARGS-1-gi] with the root emerging from instance gi-1.
        shift_register_with_valid #(
          .DEPTH (gi * L),
          .WIDTH (W)
        ) u_delay (
          .clk      (clk),
          .rst      (rst_hi),
          .in_vld   (arg_vld),
          .in_data  (args[(N_ARGS-1-gi)*W +: W]),
          .out_vld  (dl_vld),
          .out_data (dl_data)
        );

        // Combinational adder with wrap or clamp on carry-out.
        always_comb begin
          sum_wide = {1'b0, dl_data} + {{(W/2+1){1'b0}}, iq_root[gi-1]};
          sum      = sum_wide[W-1:0];
          if (SATURATE != 0 && sum_wide[W]) sum = '1;
        end

        assign st_vld[gi] = dl_vld;
        assign st_in[gi]  = sum;
      end

      isqrt #(
        .W             (W),
        .N_PIPE_STAGES (L)
      ) u_isqrt (
        .clk      (clk),
        .rst      (rst_hi),
        .in_vld   (st_vld[gi]),
        .in_data  (st_in[gi]),
        .out_vld  (iq_vld[gi]),
        .out_root (iq_root[gi])
      );
    end
  endgenerate

  // Inner-stage valids duplicate the delay-line valids and are not consumed.
  logic unused_vld;
  assign unused_vld = ^iq_vld;

  assign res_vld = iq_vld[N_ARGS-1];
  assign res     = iq_root[N_ARGS-1];

  logic [CW-1:0] in_flight_d, in_flight_q;

  // Occupancy: count up on accept, down on result, hold when both or neither.
  always_comb begin
    in_flight_d = in_flight_q;
    if (arg_vld && !res_vld)      in_flight_d = in_flight_q + CW'(1);
    else if (!arg_vld && res_vld) in_flight_d = in_flight_q - CW'(1);
  end

  // Occupancy register with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in_flight_q <= '0;
    else      in_flight_q <= in_flight_d;
  end

  // Occupancy must stay within 0..MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(arg_vld && !res_vld && in_flight_q == CW'(MAX)));
      assert (!(!arg_vld && res_vld && in_flight_q == '0));
    end
  end

  assign in_flight = in_flight_q;
  assign busy      = (in_flight_q != '0);
endmodule
